mem_arb_banked: RTL and testbench
=================================

MEM_ARB_BANKED -- requirements
Module: mem_arb_banked

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width of both request ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width; legal values are multiples of 8.
REQ-003 The block SHALL have parameter BANKS, default 2, meaning number of word-interleaved SRAM banks; legal values are powers of two, 1 to 8.
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning cycles from grant to rvalid; legal values are 1 to 4.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-006 Ports (name, direction, width, meaning), one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction byte address
- i_gnt  out  1  instruction request accepted this cycle
- i_rvalid  out  1  instruction read data valid
- i_rdata  out  DATA_W  instruction read data
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_be  in  DATA_W/8  data byte enables, active-high
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  data write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  DATA_W  data read data
- bank_ceb  out  BANKS  per-bank chip enable, active-low
- bank_web  out  BANKS  per-bank write enable, active-low (1 = read)
- bank_bweb  out  BANKS*DATA_W  per-bank bit write enable, active-low
- bank_a  out  BANKS*(ADDR_W-2-log2(BANKS))  per-bank word address
- bank_di  out  BANKS*DATA_W  per-bank write data
- bank_do  in  BANKS*DATA_W  per-bank read data, valid one cycle after a read access

Function
REQ-007 Bank select SHALL be addr[2 +: log2(BANKS)]; bank word address SHALL be addr[ADDR_W-1 : 2+log2(BANKS)]; addr[1:0] SHALL be ignored; with BANKS=1 bank select is constant 0.
REQ-008 Grant SHALL be combinational in the request cycle; bank access SHALL occur in the same cycle as grant.
REQ-009 Requests to different banks in the same cycle SHALL both be granted.
REQ-010 On a same-bank conflict exactly one port SHALL be granted; the loser receives gnt=0 and must hold its request.
REQ-011 An idle bank SHALL drive ceb=1, web=1, bweb all ones; address and di are don't-care.
REQ-012 A granted write SHALL drive ceb=0, web=0, and bweb byte k = ~{8{d_be[k]}}; no rvalid SHALL follow.
REQ-013 A granted read SHALL drive ceb=0, web=1, bweb all ones; rvalid SHALL assert exactly RD_LAT cycles after grant, with rdata taken from the granted bank's DO, plus RD_LAT-1 register stages.
REQ-014 The response pipeline SHALL track port valid and bank index per stage, so back-to-back reads to alternating banks return in order with one rdata per cycle.
REQ-015 rdata SHALL be zero whenever rvalid=0.
REQ-016 A d_we=1 request with d_be all zero SHALL still be granted, and the bank SHALL receive ceb=0 with bweb all ones.

Reset
REQ-017 While rst=1: i_gnt, d_gnt, i_rvalid, and d_rvalid SHALL be 0; all ceb, web, and bweb bits SHALL be 1; rdata outputs SHALL be 0.
REQ-018 Reset asserted with reads in flight SHALL discard them; no rvalid SHALL appear after reset deasserts.
REQ-019 The round-robin pointer SHALL reset to favour the data port.

Configuration
REQ-020 With macro MEM_ARB_RR_EN defined, same-bank conflicts SHALL be resolved round-robin: the last losing port wins the next conflict, and the pointer updates only on conflicts.
REQ-021 Without MEM_ARB_RR_EN, the data port SHALL always win same-bank conflicts.

Verification
REQ-022 Use BANKS=2, RD_LAT=1. Drive i_addr=0x0000 and d_addr=0x0004 in the same cycle, both reads. Both grants SHALL be 1, and both rvalid SHALL assert the next cycle with the respective bank words.
REQ-023 Drive i_addr=0x0008 and d_addr=0x0010 (both bank 0) for 3 cycles. Without the macro, d_gnt SHALL be 1 all 3 cycles and i_gnt 0. With the macro, grants SHALL alternate d, i, d.
REQ-024 Write d_be=4'b0101, d_wdata=0xAABBCCDD to 0x0004 over a prior value of 0x11223344, then read the same address. Readback SHALL be 0x11BB33DD.
REQ-025 Use RD_LAT=3. Issue d-port reads at 0x0000, 0x0004, and 0x0008 on consecutive cycles. d_rvalid SHALL be high in cycles 3, 4, and 5, with data in order.
REQ-026 Grant a read, then assert rst for 1 cycle during the RD_LAT window. No rvalid SHALL occur, and all ceb bits SHALL be 1 during reset.

Source files
------------

// File: rtl/mem_arb_banked.sv
// mem_arb_banked: two-port (instruction read / data read-write) arbiter over word-interleaved SRAM banks.
// Define MEM_ARB_RR_EN for round-robin same-bank conflict resolution; otherwise the data port always wins.
module mem_arb_banked #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int BANKS  = 2,
    parameter int RD_LAT = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_req,
    input  logic [ADDR_W-1:0]                           i_addr,
    output logic                                        i_gnt,
    output logic                                        i_rvalid,
    output logic [DATA_W-1:0]                           i_rdata,
    input  logic                                        d_req,
    input  logic                                        d_we,
    input  logic [DATA_W/8-1:0]                         d_be,
    input  logic [ADDR_W-1:0]                           d_addr,
    input  logic [DATA_W-1:0]                           d_wdata,
    output logic                                        d_gnt,
    output logic                                        d_rvalid,
    output logic [DATA_W-1:0]                           d_rdata,
    output logic [BANKS-1:0]                            bank_ceb,
    output logic [BANKS-1:0]                            bank_web,
    output logic [BANKS*DATA_W-1:0]                     bank_bweb,
    output logic [BANKS*(ADDR_W-2-$clog2(BANKS))-1:0]   bank_a,
    output logic [BANKS*DATA_W-1:0]                     bank_di,
    input  logic [BANKS*DATA_W-1:0]                     bank_do
);
    localparam int SB = $clog2(BANKS);
    localparam int BW = (SB > 0) ? SB : 1;
    localparam int AW = ADDR_W - 2 - SB;
    localparam int NB = DATA_W / 8;

    logic [BW-1:0]     i_bank, d_bank, ib_q, db_q;
    logic [AW-1:0]     i_word, d_word;
    logic              conflict, d_win, d_wr;
    logic [DATA_W-1:0] be_bits, i_do, d_do, i_dat, d_dat;
    logic [RD_LAT-1:0] iv_q, iv_d, dv_q, dv_d;

    assign i_bank   = BW'((i_addr >> 2) & ADDR_W'(BANKS - 1));
    assign d_bank   = BW'((d_addr >> 2) & ADDR_W'(BANKS - 1));
    assign i_word   = AW'(i_addr >> (2 + SB));
    assign d_word   = AW'(d_addr >> (2 + SB));
    assign conflict = i_req & d_req & (i_bank == d_bank);
    assign i_gnt    = ~rst & i_req & ~(conflict & d_win);
    assign d_gnt    = ~rst & d_req & ~(conflict & ~d_win);
    assign d_wr     = d_gnt & d_we;

`ifdef MEM_ARB_RR_EN
    logic rr_q, rr_d;
    // rr_q=1 favours the data port; the loser of each conflict gets priority next time
    assign rr_d  = conflict ? ~rr_q : rr_q;
    assign d_win = rr_q;
    always_ff @(posedge clk) rr_q <= rst ? 1'b1 : rr_d;
`else
    assign d_win = 1'b1;
`endif

    always_comb begin
        for (int k = 0; k < NB; k++) be_bits[8*k +: 8] = {8{d_be[k]}};
        for (int b = 0; b < BANKS; b++) begin
            bank_ceb[b]                   = ~((i_gnt && i_bank == BW'(b)) || (d_gnt && d_bank == BW'(b)));
            bank_web[b]                   = ~(d_wr && d_bank == BW'(b));
            bank_bweb[b*DATA_W +: DATA_W] = (d_wr && d_bank == BW'(b)) ? ~be_bits : '1;
            bank_a[b*AW +: AW]            = (d_gnt && d_bank == BW'(b)) ? d_word : i_word;
            bank_di[b*DATA_W +: DATA_W]   = d_wdata;
        end
    end

    assign iv_d = (iv_q << 1) | RD_LAT'(i_gnt);
    assign dv_d = (dv_q << 1) | RD_LAT'(d_gnt & ~d_we);

    always_ff @(posedge clk) begin
        iv_q <= rst ? '0 : iv_d;
        dv_q <= rst ? '0 : dv_d;
        ib_q <= i_bank;
        db_q <= d_bank;
    end

    // bank DO is valid the cycle after access; later stages only delay the selected word
    assign i_do = bank_do[ib_q*DATA_W +: DATA_W];
    assign d_do = bank_do[db_q*DATA_W +: DATA_W];

    if (RD_LAT == 1) begin : g_lat1
        assign i_dat = i_do;
        assign d_dat = d_do;
    end else begin : g_latn
        logic [DATA_W-1:0] id_q [RD_LAT-1];
        logic [DATA_W-1:0] dd_q [RD_LAT-1];
        always_ff @(posedge clk) begin
            id_q[0] <= i_do;
            dd_q[0] <= d_do;
            for (int s = 1; s < RD_LAT - 1; s++) begin
                id_q[s] <= id_q[s-1];
                dd_q[s] <= dd_q[s-1];
            end
        end
        assign i_dat = id_q[RD_LAT-2];
        assign d_dat = dd_q[RD_LAT-2];
    end

    assign i_rvalid = ~rst & iv_q[RD_LAT-1];
    assign d_rvalid = ~rst & dv_q[RD_LAT-1];
    assign i_rdata  = i_rvalid ? i_dat : '0;
    assign d_rdata  = d_rvalid ? d_dat : '0;
endmodule

// File: tb/tb_mem_arb_banked.sv
// tb_mem_arb_banked: directed checks of mem_arb_banked with BANKS=2 at RD_LAT=1 (u1) and RD_LAT=3 (u3).
// Both instances share stimulus and each drives its own behavioural SRAM banks.
module tb_mem_arb_banked;
    logic        clk, rst;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;

    logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, i_gnt3, i_rvalid3, d_gnt3, d_rvalid3;
    logic [31:0] i_rdata1, d_rdata1, i_rdata3, d_rdata3;
    logic [1:0]  ceb1, web1, ceb3, web3;
    logic [63:0] bweb1, di1, do1, bweb3, di3, do3;
    logic [25:0] a1, a3;

    logic [31:0] mem1 [2][8192];
    logic [31:0] mem3 [2][8192];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arb_banked #(.ADDR_W(16), .DATA_W(32), .BANKS(2), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .bank_ceb(ceb1), .bank_web(web1), .bank_bweb(bweb1), .bank_a(a1), .bank_di(di1), .bank_do(do1)
    );

    mem_arb_banked #(.ADDR_W(16), .DATA_W(32), .BANKS(2), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .bank_ceb(ceb3), .bank_web(web3), .bank_bweb(bweb3), .bank_a(a3), .bank_di(di3), .bank_do(do3)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk)
        for (int b = 0; b < 2; b++)
            if (!ceb1[b]) begin
                if (!web1[b])
                    mem1[b][a1[b*13 +: 13]] <= (mem1[b][a1[b*13 +: 13]] & bweb1[b*32 +: 32]) | (di1[b*32 +: 32] & ~bweb1[b*32 +: 32]);
                else
                    do1[b*32 +: 32] <= mem1[b][a1[b*13 +: 13]];
            end

    always @(posedge clk)
        for (int b = 0; b < 2; b++)
            if (!ceb3[b]) begin
                if (!web3[b])
                    mem3[b][a3[b*13 +: 13]] <= (mem3[b][a3[b*13 +: 13]] & bweb3[b*32 +: 32]) | (di3[b*32 +: 32] & ~bweb3[b*32 +: 32]);
                else
                    do3[b*32 +: 32] <= mem3[b][a3[b*13 +: 13]];
            end

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  be;
        logic [15:0] da;
        logic [31:0] wd;
        logic        eig;
        logic        edg;
        logic [1:0]  eceb;
        logic [1:0]  eweb;
        logic [63:0] ebweb;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                         input logic [3:0] be, input logic [15:0] da, input logic [31:0] wd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = wd;
    endtask

    task automatic idle();
        drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
    endtask

    vec_t        tv [8];
    logic [31:0] exp_rd [3];
    logic [15:0] rd_addr [3];
    logic        exp_dg [3];

    initial begin
        tv[0] = '{0, 16'h0000, 1, 1, 4'hF, 16'h0000, 32'h10203040, 0, 1, 2'b10, 2'b10, 64'hFFFFFFFF_00000000};
        tv[1] = '{1, 16'h0008, 1, 1, 4'hF, 16'h0004, 32'h11223344, 1, 1, 2'b00, 2'b01, 64'h00000000_FFFFFFFF};
        tv[2] = '{1, 16'h0000, 1, 1, 4'hF, 16'h0008, 32'h55667788, 0, 1, 2'b10, 2'b10, 64'hFFFFFFFF_00000000};
        tv[3] = '{0, 16'h0000, 1, 1, 4'hF, 16'h000C, 32'hCAFEF00D, 0, 1, 2'b01, 2'b01, 64'h00000000_FFFFFFFF};
        tv[4] = '{0, 16'h0000, 1, 1, 4'h0, 16'h000C, 32'hFFFFFFFF, 0, 1, 2'b01, 2'b01, 64'hFFFFFFFF_FFFFFFFF};
        tv[5] = '{1, 16'h0004, 0, 0, 4'h0, 16'h0000, 32'h0,        1, 0, 2'b01, 2'b11, 64'hFFFFFFFF_FFFFFFFF};
        tv[6] = '{0, 16'h0000, 0, 0, 4'h0, 16'h0000, 32'h0,        0, 0, 2'b11, 2'b11, 64'hFFFFFFFF_FFFFFFFF};
        tv[7] = '{0, 16'h0000, 1, 1, 4'h6, 16'h0010, 32'h12345678, 0, 1, 2'b10, 2'b10, 64'hFFFFFFFF_FF0000FF};
        exp_rd  = '{32'h10203040, 32'h11BB33DD, 32'h55667788};
        rd_addr = '{16'h0000, 16'h0004, 16'h0008};
`ifdef MEM_ARB_RR_EN
        exp_dg = '{1'b1, 1'b0, 1'b1};
`else
        exp_dg = '{1'b1, 1'b1, 1'b1};
`endif

        // reset with requests pending: nothing granted, banks idle
        rst = 1;
        drive(1, 16'h0000, 1, 1, 4'hF, 16'h0004, 32'hDEADBEEF);
        cyc(); cyc(); #2;
        chk("rst i_gnt", i_gnt1, 0);
        chk("rst d_gnt", d_gnt1, 0);
        chk("rst ceb", ceb1, 2'b11);
        chk("rst web", web1, 2'b11);
        chk("rst bweb", bweb1, 64'hFFFFFFFF_FFFFFFFF);
        chk("rst rvalid", {i_rvalid1, d_rvalid1, i_rvalid3, d_rvalid3}, 0);
        chk("rst rdata", {i_rdata1, d_rdata1}, 0);
        cyc();
        rst = 0;
        idle();

        for (int n = 0; n < 8; n++) begin
            cyc();
            drive(tv[n].ir, tv[n].ia, tv[n].dr, tv[n].dw, tv[n].be, tv[n].da, tv[n].wd);
            #2;
            chk($sformatf("vec%0d i_gnt", n), i_gnt1, tv[n].eig);
            chk($sformatf("vec%0d d_gnt", n), d_gnt1, tv[n].edg);
            chk($sformatf("vec%0d ceb", n), ceb1, tv[n].eceb);
            chk($sformatf("vec%0d web", n), web1, tv[n].eweb);
            chk($sformatf("vec%0d bweb", n), bweb1, tv[n].ebweb);
            chk($sformatf("vec%0d ceb lat3", n), ceb3, tv[n].eceb);
        end

        // parallel reads to both banks, then a read of the word hit by the zero-enable write
        cyc(); drive(1, 16'h0000, 1, 0, 4'hF, 16'h0004, 32'h0); #2;
        chk("par i_gnt", i_gnt1, 1);
        chk("par d_gnt", d_gnt1, 1);
        cyc(); drive(1, 16'h000C, 0, 0, 4'h0, 16'h0000, 32'h0); #2;
        chk("par i_rvalid", i_rvalid1, 1);
        chk("par i_rdata", i_rdata1, 32'h10203040);
        chk("par d_rvalid", d_rvalid1, 1);
        chk("par d_rdata", d_rdata1, 32'h11223344);
        cyc(); idle(); #2;
        chk("be0 i_rdata", i_rdata1, 32'hCAFEF00D);
        chk("idle d_rvalid", d_rvalid1, 0);
        chk("idle d_rdata", d_rdata1, 0);
        cyc(); #2;
        chk("idle i_rvalid", i_rvalid1, 0);
        chk("idle i_rdata", i_rdata1, 0);

        // partial byte-enable write then readback
        cyc(); drive(0, 16'h0000, 1, 1, 4'b0101, 16'h0004, 32'hAABBCCDD); #2;
        chk("bw d_gnt", d_gnt1, 1);
        chk("bw bweb", bweb1, 64'hFF00FF00_FFFFFFFF);
        cyc(); drive(0, 16'h0000, 1, 0, 4'hF, 16'h0004, 32'h0); #2;
        chk("bw no rvalid", d_rvalid1, 0);
        cyc(); idle(); #2;
        chk("bw rvalid", d_rvalid1, 1);
        chk("bw rdata", d_rdata1, 32'h11BB33DD);
        repeat (4) cyc();

        // back-to-back reads: in-order return at both latencies
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (k < 3) drive(0, 16'h0000, 1, 0, 4'hF, rd_addr[k], 32'h0);
            else idle();
            #2;
            chk($sformatf("b2b c%0d lat3 rvalid", k), d_rvalid3, (k >= 3 && k <= 5));
            chk($sformatf("b2b c%0d lat3 rdata", k), d_rdata3, (k >= 3 && k <= 5) ? exp_rd[k-3] : 32'h0);
            chk($sformatf("b2b c%0d lat1 rvalid", k), d_rvalid1, (k >= 1 && k <= 3));
            chk($sformatf("b2b c%0d lat1 rdata", k), d_rdata1, (k >= 1 && k <= 3) ? exp_rd[k-1] : 32'h0);
        end

        // reset with reads in flight discards them
        cyc(); drive(0, 16'h0000, 1, 0, 4'hF, 16'h0008, 32'h0); #2;
        chk("flush d_gnt", d_gnt1, 1);
        cyc(); rst = 1; drive(1, 16'h0000, 1, 0, 4'hF, 16'h0004, 32'h0); #2;
        chk("flush rst gnt", {i_gnt1, d_gnt1, i_gnt3, d_gnt3}, 0);
        chk("flush rst ceb", {ceb1, ceb3}, 4'hF);
        chk("flush rst rvalid", {d_rvalid1, d_rvalid3}, 0);
        chk("flush rst rdata", d_rdata1, 0);
        cyc(); rst = 0; idle();
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("flush c%0d rvalid", k), {i_rvalid1, d_rvalid1, i_rvalid3, d_rvalid3}, 0);
            chk($sformatf("flush c%0d rdata", k), d_rdata3, 0);
            cyc();
        end

        // same-bank conflict for three cycles, pointer fresh from reset
        for (int k = 0; k < 3; k++) begin
            cyc(); drive(1, 16'h0008, 1, 0, 4'hF, 16'h0010, 32'h0); #2;
            chk($sformatf("conf c%0d d_gnt", k), d_gnt1, exp_dg[k]);
            chk($sformatf("conf c%0d i_gnt", k), i_gnt1, !exp_dg[k]);
        end
        cyc(); idle();
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
